// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_e;

  localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
  localparam logic [4:0]  ALU_MUL     = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MUL     = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

endpackage

// File: rtl/md_decode.sv
// Combinational decode of R-type mul/div from the execute-stage word.
module md_decode
  import multdiv_pkg::*;
(
  input  logic [31:0] q_imem,
  input  logic        valid,
  output logic        is_mul,
  output logic        is_div,
  output logic [4:0]  rd
);

  logic [4:0] opcode;
  logic [4:0] alu_op;
  logic       rtype;
  logic       unused_bits;

  assign opcode = q_imem[31:27];
  assign rd     = q_imem[26:22];
  assign alu_op = q_imem[6:2];
  assign rtype  = valid & (opcode == OPC_RTYPE);

  assign is_mul = rtype & (alu_op == ALU_MUL);
  assign is_div = rtype & (alu_op == ALU_DIV);

  assign unused_bits = ^{q_imem[21:7], q_imem[1:0]};

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Multiply/divide issue, stall and writeback sequencer.
// Define MULTDIV_TIMEOUT_EN to force an exception after TIMEOUT_CYCLES.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] q_imem,
  input  logic        valid,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  md_state_e  state;
  logic       is_mul;
  logic       is_div;
  logic       is_md;
  logic [4:0] dec_rd;
  logic [4:0] rd_q;
  logic       op_div_q;
  logic       accept;
  logic       tmo;

  md_decode u_decode (
    .q_imem (q_imem),
    .valid  (valid),
    .is_mul (is_mul),
    .is_div (is_div),
    .rd     (dec_rd)
  );

  assign is_md = is_mul | is_div;
  assign stall = ((state == IDLE) & is_md)
               | (state == BUSY);
  assign busy  = (state != IDLE);

  // The start-pulse cycle is the first BUSY cycle; ready is ignored there.
  assign accept = md_ready & ~(ctrl_mult | ctrl_div);

`ifdef MULTDIV_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = (state == BUSY)
             & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;

  assign tmo = 1'b0;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      wb_we     <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      rd_q      <= '0;
      op_div_q  <= 1'b0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      wb_we     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_md) begin
            rd_q      <= dec_rd;
            op_div_q  <= is_div;
            ctrl_mult <= is_mul;
            ctrl_div  <= is_div;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (accept & ~md_exception) begin
            wb_we   <= (rd_q != 5'd0);
            wb_reg  <= rd_q;
            wb_data <= md_result;
            state   <= DONE;
          end else if (accept | tmo) begin
            wb_we   <= 1'b1;
            wb_reg  <= RSTATUS_REG;
            wb_data <= op_div_q ? EXC_DIV : EXC_MUL;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Directed self-checking bench for multdiv_seq_ctrl.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_multdiv_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] q_imem;
  logic        valid;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int stall_cnt = 0;

  localparam logic [4:0] RT  = 5'b00000;
  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  always #5 clock = ~clock;

  multdiv_seq_ctrl #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (6)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .q_imem       (q_imem),
    .valid        (valid),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .md_result    (md_result),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .stall        (stall),
    .busy         (busy),
    .wb_we        (wb_we),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data)
  );

  function automatic logic [31:0] mk(
    input logic [4:0] op,
    input logic [4:0] rd,
    input logic [4:0] alu
  );
    return {op, rd, 15'd0, alu, 2'b00};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset_n      = 1'b0;
    valid        = 1'b1;
    q_imem       = mk(RT, 5'd5, MUL);
    md_ready     = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;

    // reset held with a mul present
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("rst_busy", busy, 0);
      chk("rst_pulse", ctrl_mult, 0);
      chk("rst_we", wb_we, 0);
    end
    chk("rst_reg", wb_reg, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_stall", stall, 1);

    // mul r5: cycle t
    @(negedge clock); reset_n = 1'b1; #1;
    chk("t_stall", stall, 1);
    chk("t_busy", busy, 0);
    chk("t_nopulse", ctrl_mult, 0);
    stall_cnt = int'(stall);
    // t+1: pulse, ready here must be ignored
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'hdead; #1;
    chk("mul_pulse", ctrl_mult, 1);
    chk("mul_nodiv", ctrl_div, 0);
    stall_cnt += int'(stall);
    @(negedge clock); md_ready = 1'b0; #1;
    chk("pulse_once", ctrl_mult, 0);
    chk("ready_ign", wb_we, 0);
    chk("busy_t2", busy, 1);
    stall_cnt += int'(stall);
    @(negedge clock); #1;
    stall_cnt += int'(stall);
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h30; #1;
    stall_cnt += int'(stall);
    // DONE; next instruction already presented
    @(negedge clock);
    md_ready = 1'b0; q_imem = mk(RT, 5'd7, DIV); #1;
    chk("mul_we", wb_we, 1);
    chk("mul_reg", wb_reg, 5);
    chk("mul_data", wb_data, 32'h30);
    chk("done_stall", stall, 0);
    chk("mul_stall_n", stall_cnt, 5);

    // div r7 with exception
    @(negedge clock); #1;
    chk("idle_we", wb_we, 0);
    chk("hold_reg", wb_reg, 5);
    chk("hold_data", wb_data, 32'h30);
    chk("div_stall", stall, 1);
    @(negedge clock); q_imem = mk(RT, 5'd9, MUL); #1;
    chk("div_pulse", ctrl_div, 1);
    chk("div_nomul", ctrl_mult, 0);
    @(negedge clock);
    md_ready = 1'b1; md_exception = 1'b1;
    md_result = 32'h99; #1;
    chk("div_once", ctrl_div, 0);
    @(negedge clock);
    md_ready = 1'b0; md_exception = 1'b0; valid = 1'b0; #1;
    chk("div_we", wb_we, 1);
    chk("div_reg", wb_reg, 30);
    chk("div_data", wb_data, 5);
    @(negedge clock); #1;
    chk("div_idle", busy, 0);
    chk("div_we_off", wb_we, 0);

    // mul r0: no write, sequence still completes
    @(negedge clock);
    valid = 1'b1; q_imem = mk(RT, 5'd0, MUL); #1;
    chk("r0_stall", stall, 1);
    @(negedge clock); #1;
    chk("r0_pulse", ctrl_mult, 1);
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h1234; #1;
    @(negedge clock); md_ready = 1'b0; valid = 1'b0; #1;
    chk("r0_we", wb_we, 0);
    chk("r0_stall_off", stall, 0);
    chk("r0_busy", busy, 1);
    chk("r0_data", wb_data, 32'h1234);
    @(negedge clock); #1;
    chk("r0_idle", busy, 0);

    // mul r3 with md_ready never arriving
    @(negedge clock);
    valid = 1'b1; q_imem = mk(RT, 5'd3, MUL); #1;
    @(negedge clock); valid = 1'b0; #1;
    chk("tmo_pulse", ctrl_mult, 1);
`ifdef MULTDIV_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      @(negedge clock); #1;
    end
    chk("tmo_busy8", stall, 1);
    chk("tmo_pre_we", wb_we, 0);
    @(negedge clock); #1;
    chk("tmo_we", wb_we, 1);
    chk("tmo_reg", wb_reg, 30);
    chk("tmo_data", wb_data, 4);
`else
    repeat (12) @(negedge clock);
    #1;
    chk("wait_stall", stall, 1);
    chk("wait_we", wb_we, 0);
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h55; #1;
    @(negedge clock); md_ready = 1'b0; #1;
    chk("wait_we2", wb_we, 1);
    chk("wait_reg", wb_reg, 3);
    chk("wait_data", wb_data, 32'h55);
`endif
    @(negedge clock); #1;
    chk("tmo_idle", busy, 0);

    // back-to-back mul r4 then div r6, reset mid-div
    @(negedge clock);
    valid = 1'b1; q_imem = mk(RT, 5'd4, MUL); #1;
    @(negedge clock); #1;
    chk("b2b_mpulse", ctrl_mult, 1);
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h77; #1;
    @(negedge clock);
    md_ready = 1'b0; q_imem = mk(RT, 5'd6, DIV); #1;
    chk("b2b_we", wb_we, 1);
    chk("b2b_reg", wb_reg, 4);
    chk("b2b_data", wb_data, 32'h77);
    @(negedge clock); #1;
    chk("b2b_stall", stall, 1);
    @(negedge clock); #1;
    chk("b2b_dpulse", ctrl_div, 1);
    @(negedge clock); reset_n = 1'b0; valid = 1'b0; #1;
    @(negedge clock); #1;
    chk("abort_busy", busy, 0);
    chk("abort_pulse", ctrl_div, 0);
    chk("abort_we", wb_we, 0);
    chk("abort_data", wb_data, 0);
    @(negedge clock); reset_n = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("post_pulse", ctrl_div, 0);
      chk("post_we", wb_we, 0);
      chk("post_busy", busy, 0);
    end

    // non-matching encodings never stall
    @(negedge clock);
    valid = 1'b1; q_imem = mk(5'b00001, 5'd2, MUL); #1;
    chk("dec_opc", stall, 0);
    @(negedge clock); q_imem = mk(RT, 5'd2, 5'b00101); #1;
    chk("dec_alu", stall, 0);
    @(negedge clock); valid = 1'b0; #1;
    chk("dec_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
